mem_port_arbiter: RTL and testbench

//  Shares the single-port 1Kx8 inferred RAM (meminferida) between two requesters, A and B.

---
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-port sync RAM between
// requesters A and B, with per-access ack pulses and registered read return.
// Latency: ack one cycle after an eligible request, rvalid two cycles after ack.
// Backpressure: requests are held until ack, and an acked requester sits out the next grant.
//
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   req_x/we_x/addr_x/wdata_x (x=a,b)  request side, held stable until ack_x
//   ack_x, rvalid_x, rdata_x           grant pulse, read-return pulse and data
//   mem_we/mem_addr/mem_di, mem_do     RAM port (DO valid one clock after addr)
//
// Optional feature macro: MEM_PORT_ARBITER_LOCK_EN adds lock_a/lock_b inputs
// that let the granted requester hold the RAM for a run of accesses.
module mem_port_arbiter #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
`ifdef MEM_PORT_ARBITER_LOCK_EN
  input  logic          lock_a,
  input  logic          lock_b,
`endif
  output logic          ack_a,
  output logic          rvalid_a,
  output logic [DW-1:0] rdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
  output logic          ack_b,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata_b,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_di,
  input  logic [DW-1:0] mem_do
);

  typedef enum logic [1:0] {S_IDLE, S_GNT_A, S_GNT_B} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_ack_a, r_ack_b;
  logic            r_last_b;      // 1: most recent grant went to B
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_di;
  logic            r_rd_vld;      // a read was on the RAM port last cycle
  logic            r_rd_tag_b;    // ...and it belongs to B
  logic            r_rvalid_a, r_rvalid_b;
  logic [DW-1:0]   r_rdata_a, r_rdata_b;
  logic            w_elig_a, w_elig_b;
  logic            w_blk_a, w_blk_b;

`ifdef MEM_PORT_ARBITER_LOCK_EN
  logic r_lock_a, r_lock_b;
  logic w_own_a, w_own_b;
  // During an ack cycle the live lock input decides whether ownership
  // continues; otherwise the registered ownership stands.
  assign w_own_a = r_ack_a ? lock_a : r_lock_a;
  assign w_own_b = r_ack_b ? lock_b : r_lock_b;
  assign w_blk_a = w_own_b;
  assign w_blk_b = w_own_a;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_a <= 1'b0;
      r_lock_b <= 1'b0;
    end else begin
      r_lock_a <= w_own_a;
      r_lock_b <= w_own_b;
    end
  end
`else
  assign w_blk_a = 1'b0;
  assign w_blk_b = 1'b0;
`endif

  // A requester acked this cycle is skipped at the next edge, which is what
  // gives interleaving when both are busy.
  assign w_elig_a = req_a & ~r_ack_a & ~w_blk_a;
  assign w_elig_b = req_b & ~r_ack_b & ~w_blk_b;

  always_comb begin
    w_state_nxt = S_IDLE;
    if (w_elig_a && w_elig_b) begin
      w_state_nxt = r_last_b ? S_GNT_A : S_GNT_B;
    end else if (w_elig_a) begin
      w_state_nxt = S_GNT_A;
    end else if (w_elig_b) begin
      w_state_nxt = S_GNT_B;
    end
  end

  // last_grant follows every grant; under a lock only the owner is granted,
  // so it settles on the owner when the lock ends.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ack_a    <= 1'b0;
      r_ack_b    <= 1'b0;
      r_last_b   <= 1'b1;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_di   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack_a <= (w_state_nxt == S_GNT_A);
      r_ack_b <= (w_state_nxt == S_GNT_B);
      case (w_state_nxt)
        S_GNT_A: begin
          r_mem_we   <= we_a;
          r_mem_addr <= addr_a;
          r_mem_di   <= wdata_a;
          r_last_b   <= 1'b0;
        end
        S_GNT_B: begin
          r_mem_we   <= we_b;
          r_mem_addr <= addr_b;
          r_mem_di   <= wdata_b;
          r_last_b   <= 1'b1;
        end
        default: r_mem_we <= 1'b0;
      endcase
    end
  end

  // Read return: stage 1 marks the cycle in which DO carries the data,
  // stage 2 registers DO into the tagged requester's result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_vld   <= 1'b0;
      r_rd_tag_b <= 1'b0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_rdata_a  <= '0;
      r_rdata_b  <= '0;
    end else begin
      r_rd_vld   <= (r_ack_a | r_ack_b) & ~r_mem_we;
      r_rd_tag_b <= r_ack_b;
      r_rvalid_a <= r_rd_vld & ~r_rd_tag_b;
      r_rvalid_b <= r_rd_vld &  r_rd_tag_b;
      if (r_rd_vld && !r_rd_tag_b) r_rdata_a <= mem_do;
      if (r_rd_vld &&  r_rd_tag_b) r_rdata_b <= mem_do;
    end
  end

  assign ack_a    = r_ack_a;
  assign ack_b    = r_ack_b;
  assign mem_we   = r_mem_we;
  assign mem_addr = r_mem_addr;
  assign mem_di   = r_mem_di;
  assign rvalid_a = r_rvalid_a;
  assign rvalid_b = r_rvalid_b;
  assign rdata_a  = r_rdata_a;
  assign rdata_b  = r_rdata_b;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a queue-based model.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0;
  logic [DW-1:0] wdata_a = '0, wdata_b = '0;
  logic          ack_a, ack_b, rvalid_a, rvalid_b, mem_we;
  logic [DW-1:0] rdata_a, rdata_b, mem_di;
  logic [DW-1:0] mem_do = '0;
  logic [AW-1:0] mem_addr;
`ifdef MEM_PORT_ARBITER_LOCK_EN
  logic          lock_a = 1'b0, lock_b = 1'b0;
`endif

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
`ifdef MEM_PORT_ARBITER_LOCK_EN
    .lock_a(lock_a), .lock_b(lock_b),
`endif
    .ack_a(ack_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int i);
    logic [31:0] v;
    v = i * 37 + 11;
    return (i == 5) ? 8'h3C : v[7:0];
  endfunction

  // Synchronous single-port RAM, DO registered one clock after addr.
  logic [DW-1:0] ram [1024];
  bit ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_val(i);
      ram_ready <= 1'b1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_di;
    end
    mem_do <= ram[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    bit          tag_b;
    logic [7:0]  data;
  } rd_t;

  rd_t           rq[$];
  logic [DW-1:0] shadow [1024];
  int            mcyc = 0;
  logic          e_ack_a = 0, e_ack_b = 0, e_we = 0, e_rv_a = 0, e_rv_b = 0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_di = '0, e_rd_a = '0, e_rd_b = '0;
  bit            m_last_b = 1'b1, pw = 1'b0;
  logic [AW-1:0] pwa, g_addr;
  logic [DW-1:0] pwd, g_wd;
  bit            ea, eb, g_we;
  int            g;
  rd_t           r;

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        e_ack_a = 0; e_ack_b = 0; e_we = 0; e_addr = '0; e_di = '0;
        e_rv_a = 0; e_rv_b = 0; e_rd_a = '0; e_rd_b = '0;
        m_last_b = 1'b1; pw = 1'b0; rq.delete();
      end else begin
        mcyc++;
        if (pw) shadow[pwa] = pwd;   // write issued last cycle lands now
        pw = 1'b0;
        ea = req_a && !e_ack_a;
        eb = req_b && !e_ack_b;
        g = 0;
        if (ea && eb) g = m_last_b ? 1 : 2;
        else if (ea)  g = 1;
        else if (eb)  g = 2;
        e_ack_a = (g == 1);
        e_ack_b = (g == 2);
        e_we = 1'b0;
        if (g != 0) begin
          g_we   = (g == 1) ? we_a : we_b;
          g_addr = (g == 1) ? addr_a : addr_b;
          g_wd   = (g == 1) ? wdata_a : wdata_b;
          e_addr = g_addr; e_di = g_wd; e_we = g_we;
          m_last_b = (g == 2);
          if (g_we) begin
            pw = 1'b1; pwa = g_addr; pwd = g_wd;
          end else begin
            r.due = mcyc + 2; r.tag_b = (g == 2); r.data = shadow[g_addr];
            rq.push_back(r);
          end
        end
        e_rv_a = 0; e_rv_b = 0;
        if (rq.size() > 0 && rq[0].due == mcyc) begin
          r = rq.pop_front();
          if (r.tag_b) begin e_rv_b = 1; e_rd_b = r.data; end
          else         begin e_rv_a = 1; e_rd_a = r.data; end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("m_ack_a", ack_a, e_ack_a);
      chk("m_ack_b", ack_b, e_ack_b);
      chk("m_one_ack", ack_a & ack_b, 0);
      chk("m_mem_we", mem_we, e_we);
      chk("m_mem_addr", mem_addr, e_addr);
      chk("m_mem_di", mem_di, e_di);
      chk("m_rvalid_a", rvalid_a, e_rv_a);
      chk("m_rvalid_b", rvalid_b, e_rv_b);
      chk("m_rdata_a", rdata_a, e_rd_a);
      chk("m_rdata_b", rdata_b, e_rd_b);
    end
  end

  // Reset, check reset values, release just after a rising edge (cycle 0).
  task automatic do_reset();
    req_a = 0; req_b = 0; reset_n = 0;
    @(negedge clk);
    chk("rst_ack_a", ack_a, 0);
    chk("rst_ack_b", ack_b, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_di", mem_di, 0);
    chk("rst_rvalid", {rvalid_a, rvalid_b}, 0);
    chk("rst_rdata", {rdata_a, rdata_b}, 0);
    @(posedge clk); #1 reset_n = 1;
  endtask

  task automatic idle(input int n);
    req_a = 0; req_b = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  bit seen_a, seen_b, done;
  int na;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    // 1: read from A
    do_reset();
    cmp_en = 1;
    req_a = 1; we_a = 0; addr_a = 10'h005;
    @(negedge clk);
    chk("t1_ack_c0", ack_a, 0);
    @(negedge clk);
    chk("t1_ack_c1", ack_a, 1);
    @(posedge clk); #1 req_a = 0;
    @(negedge clk);
    chk("t1_rvalid_c2", rvalid_a, 0);
    @(negedge clk);
    chk("t1_rvalid_c3", rvalid_a, 1);
    chk("t1_rdata_c3", rdata_a, 8'h3C);
    idle(4);

    // 2: simultaneous requests after reset
    do_reset();
    req_a = 1; we_a = 0; addr_a = 10'h011; req_b = 1; we_b = 0; addr_b = 10'h022;
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("t2_order", {ack_a, ack_b}, (c % 2 == 1) ? 2'b10 : 2'b01);
    end
    idle(5);

    // 3: A alone, back-to-back writes
    do_reset();
    req_a = 1; we_a = 1; addr_a = 10'h040; wdata_a = 8'h11;
    @(negedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk("t3_ack_a", ack_a, (c % 2 == 1) ? 1 : 0);
      chk("t3_mem_we", mem_we, (c % 2 == 1) ? 1 : 0);
      if (ack_a) begin
        @(posedge clk); #1 addr_a = addr_a + 1; wdata_a = wdata_a + 8'h22;
      end
    end
    idle(4);

    // 4: A writes 0x3FF, B reads it the next cycle
    do_reset();
    req_a = 1; we_a = 1; addr_a = 10'h3FF; wdata_a = 8'hA5;
    @(negedge clk);
    @(posedge clk); #1 req_a = 0; req_b = 1; we_b = 0; addr_b = 10'h3FF;
    @(negedge clk);
    chk("t4_ack_a", ack_a, 1);
    @(negedge clk);
    chk("t4_ack_b", ack_b, 1);
    @(posedge clk); #1 req_b = 0;
    @(negedge clk);
    chk("t4_rvalid_c3", rvalid_b, 0);
    @(negedge clk);
    chk("t4_rvalid_c4", rvalid_b, 1);
    chk("t4_rdata_b", rdata_b, 8'hA5);
    idle(4);

    // 5: reset one cycle after a read ack
    do_reset();
    req_a = 1; we_a = 0; addr_a = 10'h005;
    @(negedge clk);
    @(negedge clk);
    chk("t5_ack", ack_a, 1);
    @(posedge clk); #1 req_a = 0; reset_n = 0;
    #1;
    chk("t5_rst_outs", {ack_a, ack_b, mem_we, rvalid_a, rvalid_b}, 0);
    chk("t5_rst_addr", mem_addr, 0);
    chk("t5_rst_rdata", rdata_a, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t5_no_rvalid", rvalid_a, 0);
    end
    idle(2);

`ifdef MEM_PORT_ARBITER_LOCK_EN
    // 6: A locks for 3 accesses while B waits
    cmp_en = 0;
    do_reset();
    lock_a = 1; req_a = 1; we_a = 0; addr_a = 10'h001;
    req_b = 1; we_b = 0; addr_b = 10'h002;
    na = 0; done = 0;
    for (int c = 0; c < 16 && !done; c++) begin
      @(negedge clk);
      if (ack_a) na++;
      chk("t6_b_held", ack_b, 0);
      if (ack_a && !lock_a) begin
        done = 1;
        @(negedge clk);
        chk("t6_b_after", ack_b, 1);
      end else if (ack_a && na == 3) begin
        @(posedge clk); #1 lock_a = 0;
      end
    end
    chk("t6_lock_ended", done, 1);
    lock_a = 0;
    idle(4);
    do_reset();
    cmp_en = 1;
`endif

    // Randomized traffic, checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      seen_a = ack_a; seen_b = ack_b;
      @(posedge clk); #1;
      if (!req_a || seen_a) begin
        req_a = ($urandom_range(0, 3) != 0);
        we_a = $urandom_range(0, 1) == 1;
        addr_a = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 7));
        wdata_a = 8'($urandom);
      end
      if (!req_b || seen_b) begin
        req_b = ($urandom_range(0, 3) != 0);
        we_b = $urandom_range(0, 2) == 0;
        addr_b = ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 7));
        wdata_b = 8'($urandom);
      end
    end
    idle(6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
